// File: rtl/pll_rst_pkg.sv
// ---------------------------------------------------------------------------
// pll_rst_pkg
// Shared definitions for the PLL / HyperRAM reset sequencer: the sequencer
// state encoding (also exported on the debug `state` port) and a small
// helper used to size the shared cycle counter.
// ---------------------------------------------------------------------------
package pll_rst_pkg;

    localparam int STATE_W = 3;

    typedef enum logic [STATE_W-1:0] {
        WAIT_LOCK = 3'd0,
        STABLE    = 3'd1,
        RAM_RST   = 3'd2,
        RAM_INIT  = 3'd3,
        RUN       = 3'd4,
        FAULT     = 3'd5
    } state_t;

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/sync_ff2.sv
// ---------------------------------------------------------------------------
// sync_ff2
// Two-flop synchronizer for a single asynchronous level signal.
//   clk   : destination clock
//   rst_n : asynchronous active-low reset, clears both flops
//   d     : asynchronous input
//   q     : input synchronized to clk (2-cycle latency)
// ---------------------------------------------------------------------------
module sync_ff2 (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic sync_p0;
    logic sync_p1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_p0 <= 1'b0;
            sync_p1 <= 1'b0;
        end else begin
            sync_p0 <= d;
            sync_p1 <= sync_p0;
        end
    end

    assign q = sync_p1;

endmodule

// File: rtl/pll_reset_seq.sv
// ---------------------------------------------------------------------------
// pll_reset_seq
// Power-up reset sequencer: waits for a stable PLL lock, pulses the HyperRAM
// controller reset, waits for RAM init (with bounded retries), then releases
// the cartridge logic reset. Losing lock after the stable phase restarts the
// sequence and is counted; exhausting the RAM retries parks in a sticky FAULT.
//   clk           : 81 MHz logic clock (PLL clkout)
//   rst_n         : asynchronous active-low reset
//   pll_lock      : PLL lock, asynchronous to clk
//   ram_init_done : HyperRAM controller init complete (level, clk domain)
//   ram_rst_n     : active-low HyperRAM controller reset
//   sys_rst_n     : active-low cartridge logic reset
//   ready         : high only in RUN
//   fault         : high only in FAULT
//   state         : current state encoding, for debug
//   loss_count    : saturating count of lock-loss events
// ---------------------------------------------------------------------------
module pll_reset_seq
    import pll_rst_pkg::*;
#(
    parameter int LOCK_STABLE_CYCLES = 1024,
    parameter int RAM_RST_CYCLES     = 16,
    parameter int RAM_INIT_TIMEOUT   = 16200,
    parameter int MAX_RETRIES        = 3
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               pll_lock,
    input  logic               ram_init_done,
    output logic               ram_rst_n,
    output logic               sys_rst_n,
    output logic               ready,
    output logic               fault,
    output logic [STATE_W-1:0] state,
    output logic [7:0]         loss_count
);

    // One counter serves all timed states, so it is sized for the longest.
    localparam int CNT_MAX = max3(LOCK_STABLE_CYCLES, RAM_RST_CYCLES, RAM_INIT_TIMEOUT);
    localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
    localparam int RETRY_W = (MAX_RETRIES > 0) ? $clog2(MAX_RETRIES + 1) : 1;

    localparam logic [CNT_W-1:0] LOCK_LAST = CNT_W'(LOCK_STABLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] RST_LAST  = CNT_W'(RAM_RST_CYCLES - 1);
    localparam logic [CNT_W-1:0] INIT_LAST = CNT_W'(RAM_INIT_TIMEOUT - 1);

    function automatic logic [7:0] sat_inc(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    logic               lock_s;
    state_t             st, st_nxt;
    logic [CNT_W-1:0]   cnt, cnt_nxt;
    logic [RETRY_W-1:0] retry_cnt, retry_nxt;
    logic [7:0]         loss_nxt;

    sync_ff2 u_lock_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (pll_lock),
        .q     (lock_s)
    );

    always_comb begin
        st_nxt    = st;
        cnt_nxt   = cnt;
        retry_nxt = retry_cnt;
        loss_nxt  = loss_count;
        case (st)
            WAIT_LOCK: begin
                if (lock_s) begin
                    st_nxt  = STABLE;
                    cnt_nxt = '0;
                end
            end
            STABLE: begin
                // A drop before the stable window completes is just a
                // lock-acquisition glitch, not a loss event.
                if (!lock_s) begin
                    st_nxt    = WAIT_LOCK;
                    cnt_nxt   = '0;
                    retry_nxt = '0;
                end else if (cnt == LOCK_LAST) begin
                    st_nxt  = RAM_RST;
                    cnt_nxt = '0;
                end else begin
                    cnt_nxt = cnt + 1'b1;
                end
            end
            RAM_RST, RAM_INIT, RUN: begin
                // Lock loss outranks init-done, which outranks the timeout.
                if (!lock_s) begin
                    st_nxt    = WAIT_LOCK;
                    cnt_nxt   = '0;
                    retry_nxt = '0;
                    loss_nxt  = sat_inc(loss_count);
                end else if (st == RAM_RST) begin
                    if (cnt == RST_LAST) begin
                        st_nxt  = RAM_INIT;
                        cnt_nxt = '0;
                    end else begin
                        cnt_nxt = cnt + 1'b1;
                    end
                end else if (st == RAM_INIT) begin
                    if (ram_init_done) begin
                        st_nxt    = RUN;
                        cnt_nxt   = '0;
                        retry_nxt = '0;
                    end else if (cnt == INIT_LAST) begin
                        cnt_nxt   = '0;
                        retry_nxt = retry_cnt + 1'b1;
                        st_nxt    = (int'(retry_cnt) + 1 < MAX_RETRIES) ? RAM_RST : FAULT;
                    end else begin
                        cnt_nxt = cnt + 1'b1;
                    end
                end
            end
            FAULT: begin
                // Sticky: only rst_n leaves this state.
                st_nxt = FAULT;
            end
            default: begin
                st_nxt    = WAIT_LOCK;
                cnt_nxt   = '0;
                retry_nxt = '0;
            end
        endcase
    end

    // Outputs decode the next state so they update on the same edge as state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            st         <= WAIT_LOCK;
            cnt        <= '0;
            retry_cnt  <= '0;
            loss_count <= 8'd0;
            ram_rst_n  <= 1'b0;
            sys_rst_n  <= 1'b0;
            ready      <= 1'b0;
            fault      <= 1'b0;
        end else begin
            st         <= st_nxt;
            cnt        <= cnt_nxt;
            retry_cnt  <= retry_nxt;
            loss_count <= loss_nxt;
            ram_rst_n  <= (st_nxt == RAM_INIT) || (st_nxt == RUN);
            sys_rst_n  <= (st_nxt == RUN);
            ready      <= (st_nxt == RUN);
            fault      <= (st_nxt == FAULT);
        end
    end

    assign state = st;

endmodule

// File: doc/pll_reset_seq.md
PLL_RESET_SEQ -- requirements
Module: pll_reset_seq

Interface
REQ-001 SHALL have parameter LOCK_STABLE_CYCLES, default 1024: consecutive synchronized-lock cycles required before reset release.
REQ-002 SHALL have parameter RAM_RST_CYCLES, default 16: length of the HyperRAM reset pulse, in clk cycles.
REQ-003 SHALL have parameter RAM_INIT_TIMEOUT, default 16200: cycles to wait for ram_init_done (200 us at 81 MHz).
REQ-004 SHALL have parameter MAX_RETRIES, default 3: number of RAM init attempts before FAULT.
REQ-005 clk  in  1  81 MHz logic clock from the PLL clkout.
REQ-006 rst_n  in  1  asynchronous active-low reset.
REQ-007 pll_lock  in  1  PLL lock, asynchronous to clk.
REQ-008 ram_init_done  in  1  HyperRAM controller init complete, synchronous to clk, level.
REQ-009 ram_rst_n  out  1  active-low HyperRAM controller reset.
REQ-010 sys_rst_n  out  1  active-low reset for the cartridge logic.
REQ-011 ready  out  1  high only in RUN.
REQ-012 fault  out  1  high only in FAULT.
REQ-013 state  out  3  encoded current state, for debug.
REQ-014 loss_count  out  8  saturating count of lock-loss events.

Function
REQ-015 SHALL pass pll_lock through a 2-flop synchronizer (lock_s) before any use.
REQ-016 SHALL implement the states WAIT_LOCK=0, STABLE=1, RAM_RST=2, RAM_INIT=3, RUN=4, FAULT=5.
REQ-017 WAIT_LOCK: when lock_s=1 -> STABLE with the cycle counter cleared.
REQ-018 STABLE: counter increments while lock_s=1; lock_s=0 -> WAIT_LOCK, not counted as a loss; counter = LOCK_STABLE_CYCLES-1 -> RAM_RST.
REQ-019 RAM_RST: ram_rst_n=0 for exactly RAM_RST_CYCLES cycles, then -> RAM_INIT.
REQ-020 RAM_INIT: ram_rst_n=1; ram_init_done=1 -> RUN; after RAM_INIT_TIMEOUT cycles without done, increment retry_cnt; if retry_cnt+1 < MAX_RETRIES -> RAM_RST, else -> FAULT.
REQ-021 RUN: sys_rst_n=1, ram_rst_n=1, ready=1.
REQ-022 lock_s=0 in RAM_RST, RAM_INIT or RUN SHALL cause -> WAIT_LOCK and increment loss_count, which saturates at 255.
REQ-023 FAULT SHALL be sticky until rst_n is asserted; in FAULT both resets are asserted and lock is ignored.
REQ-024 Priority: lock loss > ram_init_done > timeout; simultaneous events resolve by this order.
REQ-025 retry_cnt SHALL clear on entry to RUN and on any transition to WAIT_LOCK.
REQ-026 All outputs SHALL be registered and Moore-decoded, and change on the same edge as state.
REQ-027 sys_rst_n SHALL be 0 in every state except RUN; ram_rst_n SHALL be 0 in WAIT_LOCK, STABLE, RAM_RST and FAULT.
REQ-028 Latency from a pll_lock rise to ram_rst_n=0 entry SHALL be 2 (sync) + 1 + LOCK_STABLE_CYCLES cycles.
REQ-029 Counter width SHALL be $clog2 of the largest cycle parameter, with no wrap before the compare.

Reset
REQ-030 On rst_n=0 (asynchronous): state=WAIT_LOCK, ram_rst_n=0, sys_rst_n=0, ready=0, fault=0, loss_count=0, counters=0, synchronizer=0.
REQ-031 Reset deassertion mid-operation SHALL restart the sequence from WAIT_LOCK.

Structure
REQ-032 Package pll_rst_pkg SHALL hold the state enum and the STATE_W=3 constant.
REQ-033 Synchronizer SHALL be the sub-module sync_ff2, instantiated once.

Verification (LOCK_STABLE_CYCLES=8, RAM_RST_CYCLES=4, RAM_INIT_TIMEOUT=20, MAX_RETRIES=2)
REQ-034 Nominal: pll_lock=1 at cycle 0, done 5 cycles into RAM_INIT -> ram_rst_n low for 4 cycles starting at cycle 11, then RUN; sys_rst_n=1, ready=1, loss_count=0.
REQ-035 Glitch: pll_lock high 5 cycles, low, then high -> returns to STABLE, counter restarts, loss_count stays 0.
REQ-036 Loss in RUN: drop pll_lock -> WAIT_LOCK 3 cycles later, sys_rst_n=0, loss_count=1; relock completes a full sequence.
REQ-037 Timeout: ram_init_done never asserts -> two RAM_RST pulses, then FAULT, fault=1; further lock toggles ignored until rst_n.
REQ-038 Simultaneous: lock_s falls in the same cycle ram_init_done rises -> WAIT_LOCK, never RUN, loss_count increments.
REQ-039 Saturation: 260 lock-loss events from RUN -> loss_count=255.
